// File: rtl/rom_stream_ctrl_if.sv
// Request, ROM-side and stream-side signals of rom_stream_ctrl.
// slave is the controller's view; master is the requester/ROM/consumer view.
interface rom_stream_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic                  busy;
    logic                  done;
    logic                  start_rom;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output start, base_addr, length, rom_data, out_ready,
        input  busy, done, start_rom, rom_addr, out_data, out_valid, out_last
    );

    modport slave (
        input  start, base_addr, length, rom_data, out_ready,
        output busy, done, start_rom, rom_addr, out_data, out_valid, out_last
    );
endinterface

// File: rtl/rom_stream_ctrl.sv
// Turns one (base_addr, length) request into a valid/ready stream of ROM words,
// using a 2-entry skid buffer to cover the ROM's 1-cycle read latency.
module rom_stream_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic             clk,
    input  logic             rst,
    rom_stream_ctrl_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int LEN_WIDTH  = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [LEN_WIDTH-1:0]  reads_left_q, reads_left_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    entry_t [1:0]          buf_q, buf_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic                  done_q, done_d;

    logic       accept, zero_len, pop, push, issue, last_issue, last_pop, wr_ptr;
    logic [2:0] owned;

    // Words already owned (buffered or in flight) after this cycle's pop must leave
    // room for the read issued now, so the buffer can never overflow.
    always_comb begin
        accept     = (state_q == IDLE) && bus.start;
        zero_len   = (bus.length == '0);
        pop        = (count_q != 2'd0) && bus.out_ready;
        push       = inflight_q;
        owned      = {1'b0, count_q} + {2'b0, inflight_q} - {2'b0, pop};
        issue      = (reads_left_q != '0) && (owned < 3'd2);
        last_issue = issue && (reads_left_q == LEN_WIDTH'(1));
        last_pop   = pop && buf_q[rd_ptr_q].last;
        wr_ptr     = rd_ptr_q ^ count_q[0];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept && !zero_len) state_d = RUN;
            RUN:     if (last_issue)          state_d = DRAIN;
            DRAIN:   if (last_pop)            state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = done_q;
        bus.start_rom = issue;
        bus.rom_addr  = rom_addr_d;
        bus.out_valid = (count_q != 2'd0);
        bus.out_data  = buf_q[rd_ptr_q].data;
        bus.out_last  = (count_q != 2'd0) && buf_q[rd_ptr_q].last;
    end

    // rom_addr_q remembers the last issued address so rom_addr holds between reads.
    always_comb begin
        next_addr_d     = next_addr_q;
        rom_addr_d      = rom_addr_q;
        reads_left_d    = reads_left_q;
        buf_d           = buf_q;
        rd_ptr_d        = rd_ptr_q;
        inflight_d      = issue;
        inflight_last_d = last_issue;
        count_d         = count_q + {1'b0, push} - {1'b0, pop};
        done_d          = last_pop || (accept && zero_len);
        if (accept && !zero_len) begin
            reads_left_d = bus.length;
            next_addr_d  = bus.base_addr;
        end
        if (issue) begin
            rom_addr_d   = next_addr_q;
            next_addr_d  = next_addr_q + ADDR_WIDTH'(1);
            reads_left_d = reads_left_q - LEN_WIDTH'(1);
        end
        if (push) begin
            buf_d[wr_ptr].data = bus.rom_data;
            buf_d[wr_ptr].last = inflight_last_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            next_addr_q     <= '0;
            rom_addr_q      <= '0;
            reads_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            buf_q           <= '0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
            done_q          <= 1'b0;
        end else begin
            next_addr_q     <= next_addr_d;
            rom_addr_q      <= rom_addr_d;
            reads_left_q    <= reads_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            buf_q           <= buf_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            done_q          <= done_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && count_q == 2'd2));

endmodule

// File: tb/tb_rom_stream_ctrl.sv
// Bench for rom_stream_ctrl: ROM model, burst-level reference model checked every
// cycle, directed bursts with literal expectations, then randomized traffic.
module tb_rom_stream_ctrl;
    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int AW = 3;
    localparam int LW = 4;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;

    logic [DW-1:0] rom_mem [DEPTH];

    rom_stream_ctrl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    rom_stream_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: one cycle of latency, zero when not enabled.
    always @(posedge clk) bus.rom_data <= bus.start_rom ? rom_mem[bus.rom_addr] : '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: a burst is just counts of words read and words delivered.
    int m_active = 0, m_base = 0, m_len = 0, m_issued = 0, m_popped = 0;
    int m_iss_last = 0, m_done = 0, m_last_addr = 0, m_rst_prev = 0;
    int e_valid, e_pop, e_sr, e_addr, was_active, nd;
    logic [DW-1:0] got_d[$];
    int            got_c[$];
    int            done_c[$];

    initial forever begin
        @(negedge clk);
        if (cyc > 0) begin
            was_active = m_active;
            e_valid = ((m_issued - m_iss_last - m_popped) > 0) ? 1 : 0;
            e_pop   = (e_valid != 0 && bus.out_ready === 1'b1) ? 1 : 0;
            e_sr    = (m_active != 0 && m_issued < m_len && (m_issued - m_popped - e_pop) < 2) ? 1 : 0;
            e_addr  = (e_sr != 0) ? (m_base + m_issued) % DEPTH : m_last_addr;
            chk("busy", 32'(bus.busy), 32'(m_active));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
            chk("start_rom", 32'(bus.start_rom), 32'(e_sr));
            chk("rom_addr", 32'(bus.rom_addr), 32'(e_addr));
            if (e_valid != 0) begin
                chk("out_data", 32'(bus.out_data), 32'(rom_mem[(m_base + m_popped) % DEPTH]));
                chk("out_last", 32'(bus.out_last), 32'((m_popped == m_len - 1) ? 1 : 0));
            end else begin
                chk("out_last_idle", 32'(bus.out_last), 32'd0);
            end
            if (m_rst_prev != 0) chk("out_data_after_rst", 32'(bus.out_data), 32'd0);
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                got_d.push_back(bus.out_data);
                got_c.push_back(cyc);
            end
            if (bus.done === 1'b1) done_c.push_back(cyc);
            if (rst) begin
                m_active = 0; m_issued = 0; m_popped = 0; m_iss_last = 0;
                m_done = 0; m_last_addr = 0; m_len = 0; m_base = 0;
            end else begin
                nd = 0;
                m_iss_last = e_sr;
                m_issued += e_sr;
                m_last_addr = e_addr;
                if (e_pop != 0) begin
                    if (m_popped == m_len - 1) begin
                        m_active = 0;
                        nd = 1;
                    end
                    m_popped++;
                end
                if (was_active == 0 && bus.start === 1'b1) begin
                    if (bus.length == '0) nd = 1;
                    else begin
                        m_active = 1; m_base = int'(bus.base_addr); m_len = int'(bus.length);
                        m_issued = 0; m_popped = 0; m_iss_last = 0;
                    end
                end
                m_done = nd;
            end
            m_rst_prev = rst ? 1 : 0;
        end
    end

    task automatic go(input int b, input int l, output int s);
        @(posedge clk); #1;
        bus.start = 1'b1; bus.base_addr = AW'(b); bus.length = LW'(l); s = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.base_addr = AW'($urandom); bus.length = LW'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        got_d.delete(); got_c.delete(); done_c.delete();
    endtask

    // Compare logged beats against literal words; offs < 0 skips timing checks.
    task automatic chk_burst(input string nm, input int s, input logic [DW-1:0] exp_d[$],
                             input int offs, input int done_off);
        chk({nm, "_nbeats"}, 32'(got_d.size()), 32'(exp_d.size()));
        foreach (exp_d[i]) begin
            if (i < got_d.size()) begin
                chk({nm, "_word"}, 32'(got_d[i]), 32'(exp_d[i]));
                if (offs >= 0) chk({nm, "_beat_cycle"}, 32'(got_c[i] - s), 32'(offs + i));
            end
        end
        chk({nm, "_ndone"}, 32'(done_c.size()), 32'd1);
        if (done_c.size() > 0 && done_off >= 0)
            chk({nm, "_done_cycle"}, 32'(done_c[0] - s), 32'(done_off));
    endtask

    initial begin
        logic [DW-1:0] exp[$];
        int s;
        int dummy;
        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'(8'h10 + i);
        rst = 1'b1;
        bus.start = 1'b0; bus.base_addr = '0; bus.length = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        idle(2);

        clr(); go(2, 4, s); idle(12);
        exp = '{8'h12, 8'h13, 8'h14, 8'h15};
        chk_burst("basic", s, exp, 3, 7);

        clr(); go(6, 5, s); idle(12);
        exp = '{8'h16, 8'h17, 8'h10, 8'h11, 8'h12};
        chk_burst("wrap", s, exp, 3, 8);

        clr(); go(0, 8, s);
        for (int i = 0; i < 30; i++) begin
            bus.out_ready = ~bus.out_ready;
            idle(1);
        end
        bus.out_ready = 1'b1; idle(4);
        exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        chk_burst("backpressure", s, exp, -1, -1);

        clr(); go(3, 0, s); idle(6);
        chk("len0_nbeats", 32'(got_d.size()), 32'd0);
        chk("len0_ndone", 32'(done_c.size()), 32'd1);
        if (done_c.size() > 0) chk("len0_done_cycle", 32'(done_c[0] - s), 32'd1);

        clr(); go(0, 8, s);
        idle(2);
        rst = 1'b1; idle(1);
        rst = 1'b0; idle(4);
        chk("rst_no_done", 32'(done_c.size()), 32'd0);
        clr(); go(0, 2, s); idle(8);
        exp = '{8'h10, 8'h11};
        chk_burst("after_rst", s, exp, 3, 5);

        clr(); go(1, 3, s);
        bus.start = 1'b1; bus.base_addr = 3'd5; bus.length = 4'd6;
        idle(1);
        bus.start = 1'b0; idle(10);
        exp = '{8'h11, 8'h12, 8'h13};
        chk_burst("ignored_start", s, exp, 3, 6);

        for (int i = 0; i < DEPTH; i++) rom_mem[i] = DW'($urandom);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            bus.start = ($urandom_range(0, 4) == 0);
            bus.base_addr = AW'($urandom);
            bus.length = LW'($urandom_range(0, 15));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            idle(1);
        end
        rst = 1'b0; bus.start = 1'b0; bus.out_ready = 1'b1;
        idle(40);
        dummy = 0;
        if (m_active != 0) chk("final_idle", 32'(m_active), 32'(dummy));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
